// File: rtl/deserializer.sv
// Byte-serial CPU bus receiver: rebuilds address/data cycles from the DO/lh stream,
// issues one req/ack memory access per cycle and stalls the CPU through RDY.
module deserializer #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int ERR_W          = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       DO,
    input  logic [1:0]       lh,
    input  logic             WE,
    output logic [7:0]       DI,
    output logic             RDY,
    output logic             mem_req,
    output logic             mem_we,
    output logic [15:0]      mem_addr,
    output logic [7:0]       mem_wdata,
    input  logic             mem_ack,
    input  logic [7:0]       mem_rdata,
    output logic             timeout,
    output logic [ERR_W-1:0] err_cnt
);

    localparam bit TO_EN = (TIMEOUT_CYCLES != 0);
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TO_EN ? TIMEOUT_CYCLES - 1 : 0);

    localparam logic [1:0] LH_IDLE = 2'b00;
    localparam logic [1:0] LH_ALO  = 2'b01;
    localparam logic [1:0] LH_AHI  = 2'b10;
    localparam logic [1:0] LH_WD   = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR_HI,
        S_WDATA,
        S_ACCESS,
        S_DONE
    } state_t;

    state_t           state, state_nx;
    logic [15:0]      addr_r;
    logic             we_r;
    logic [7:0]       wdata_r;
    logic [7:0]       di_r;
    logic             timeout_r;
    logic [ERR_W-1:0] err_r;
    logic [CNT_W-1:0] wait_cnt;

    logic ld_lo, ld_hi, ld_wd, proto_err, acc_done, acc_abort;

    always_comb begin
        state_nx  = state;
        ld_lo     = 1'b0;
        ld_hi     = 1'b0;
        ld_wd     = 1'b0;
        proto_err = 1'b0;
        acc_done  = 1'b0;
        acc_abort = 1'b0;
        case (state)
            // DONE behaves like IDLE so a new cycle can start back-to-back
            S_IDLE, S_DONE: begin
                state_nx = S_IDLE;
                if (lh == LH_ALO) begin
                    ld_lo    = 1'b1;
                    state_nx = S_ADDR_HI;
                end else if (lh != LH_IDLE) begin
                    proto_err = 1'b1;
                end
            end
            S_ADDR_HI: begin
                case (lh)
                    LH_AHI: begin
                        ld_hi    = 1'b1;
                        state_nx = WE ? S_WDATA : S_ACCESS;
                    end
                    LH_ALO: begin
                        proto_err = 1'b1;
                        ld_lo     = 1'b1;
                    end
                    LH_WD: begin
                        proto_err = 1'b1;
                        state_nx  = S_IDLE;
                    end
                    default: ;
                endcase
            end
            S_WDATA: begin
                case (lh)
                    LH_WD: begin
                        ld_wd    = 1'b1;
                        state_nx = S_ACCESS;
                    end
                    LH_ALO: begin
                        proto_err = 1'b1;
                        ld_lo     = 1'b1;
                        state_nx  = S_ADDR_HI;
                    end
                    LH_AHI: begin
                        proto_err = 1'b1;
                        state_nx  = S_IDLE;
                    end
                    default: ;
                endcase
            end
            S_ACCESS: begin
                proto_err = (lh != LH_IDLE);
                // An ack in the final allowed cycle still completes normally
                if (mem_ack) begin
                    acc_done = 1'b1;
                    state_nx = S_DONE;
                end else if (TO_EN && wait_cnt == TO_LAST) begin
                    acc_abort = 1'b1;
                    state_nx  = S_DONE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            addr_r    <= '0;
            we_r      <= 1'b0;
            wdata_r   <= '0;
            di_r      <= '0;
            timeout_r <= 1'b0;
            err_r     <= '0;
            wait_cnt  <= '0;
        end else begin
            state <= state_nx;
            if (ld_lo) addr_r[7:0] <= DO;
            if (ld_hi) begin
                addr_r[15:8] <= DO;
                we_r         <= WE;
            end
            if (ld_wd) wdata_r <= DO;
            if (acc_done && !we_r) di_r <= mem_rdata;
            else if (acc_abort && !we_r) di_r <= 8'hFF;
            if (acc_abort) timeout_r <= 1'b1;
            if (proto_err && err_r != '1) err_r <= err_r + ERR_W'(1);
            wait_cnt <= (state == S_ACCESS) ? wait_cnt + CNT_W'(1) : '0;
        end
    end

    assign RDY       = (state == S_IDLE) || (state == S_DONE);
    assign mem_req   = (state == S_ACCESS);
    assign mem_we    = we_r;
    assign mem_addr  = addr_r;
    assign mem_wdata = wdata_r;
    assign DI        = di_r;
    assign timeout   = timeout_r;
    assign err_cnt   = err_r;

endmodule

// File: tb/tb_deserializer.sv
// Directed bench for deserializer: read, write with waits, back-to-back,
// protocol errors with saturation, timeout abort and mid-operation reset.
module tb_deserializer;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  DO;
    logic [1:0]  lh;
    logic        WE;
    logic [7:0]  DI;
    logic        RDY;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_ack;
    logic [7:0]  mem_rdata;
    logic        timeout;
    logic [1:0]  err_cnt;

    int checks = 0;
    int errors = 0;

    deserializer #(.TIMEOUT_CYCLES(4), .ERR_W(2)) u_dut (
        .clk(clk), .reset(reset), .DO(DO), .lh(lh), .WE(WE), .DI(DI), .RDY(RDY),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .timeout(timeout), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive inputs, take one rising edge, then settle 1 time unit before checking.
    task automatic tick(input logic [1:0] l, input logic [7:0] d, input logic w,
                        input logic a, input logic [7:0] rd);
        lh = l; DO = d; WE = w; mem_ack = a; mem_rdata = rd;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_di"},    16'(DI), 16'h00);
        chk({tag, "_rdy"},   16'(RDY), 16'h1);
        chk({tag, "_req"},   16'(mem_req), 16'h0);
        chk({tag, "_we"},    16'(mem_we), 16'h0);
        chk({tag, "_addr"},  mem_addr, 16'h0000);
        chk({tag, "_wdata"}, 16'(mem_wdata), 16'h00);
        chk({tag, "_to"},    16'(timeout), 16'h0);
        chk({tag, "_err"},   16'(err_cnt), 16'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        tick(2'b00, 8'h00, 1'b0, 1'b0, 8'h00);
        tick(2'b00, 8'h00, 1'b0, 1'b0, 8'h00);
        chk_reset_outputs("rst");
        reset = 1'b0;

        // Read 1234, zero-wait ack
        tick(2'b01, 8'h34, 1'b0, 1'b0, 8'h00);
        chk("rd_rdy_ahi", 16'(RDY), 16'h0);
        chk("rd_req_ahi", 16'(mem_req), 16'h0);
        tick(2'b10, 8'h12, 1'b0, 1'b0, 8'h00);
        chk("rd_req", 16'(mem_req), 16'h1);
        chk("rd_addr", mem_addr, 16'h1234);
        chk("rd_we", 16'(mem_we), 16'h0);
        chk("rd_rdy_acc", 16'(RDY), 16'h0);
        tick(2'b00, 8'h00, 1'b0, 1'b1, 8'hA5);
        chk("rd_req_done", 16'(mem_req), 16'h0);
        chk("rd_di", 16'(DI), 16'h00A5);
        chk("rd_rdy_done", 16'(RDY), 16'h1);
        tick(2'b00, 8'h00, 1'b0, 1'b0, 8'h00);
        chk("rd_rdy_idle", 16'(RDY), 16'h1);

        // Write 0200 <- 5A with three wait cycles
        tick(2'b01, 8'h00, 1'b0, 1'b0, 8'h00);
        tick(2'b10, 8'h02, 1'b1, 1'b0, 8'h00);
        chk("wr_rdy_wd", 16'(RDY), 16'h0);
        chk("wr_req_wd", 16'(mem_req), 16'h0);
        tick(2'b11, 8'h5A, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 3; i++) begin
            chk("wr_req_hold", 16'(mem_req), 16'h1);
            chk("wr_we_hold", 16'(mem_we), 16'h1);
            chk("wr_addr_hold", mem_addr, 16'h0200);
            chk("wr_wdata_hold", 16'(mem_wdata), 16'h005A);
            tick(2'b00, 8'h00, 1'b0, 1'b0, 8'h00);
        end
        chk("wr_req_last", 16'(mem_req), 16'h1);
        chk("wr_wdata_last", 16'(mem_wdata), 16'h005A);
        tick(2'b00, 8'h00, 1'b0, 1'b1, 8'h77);
        chk("wr_req_done", 16'(mem_req), 16'h0);
        chk("wr_rdy_done", 16'(RDY), 16'h1);
        chk("wr_di_keep", 16'(DI), 16'h00A5);
        chk("wr_no_timeout", 16'(timeout), 16'h0);

        // Back-to-back: read FFFF, next cycle starts during DONE, write 0000
        tick(2'b01, 8'hFF, 1'b0, 1'b0, 8'h00);
        tick(2'b10, 8'hFF, 1'b0, 1'b0, 8'h00);
        chk("b2b_rd_addr", mem_addr, 16'hFFFF);
        chk("b2b_rd_req", 16'(mem_req), 16'h1);
        tick(2'b00, 8'h00, 1'b0, 1'b1, 8'h3C);
        chk("b2b_rdy_done1", 16'(RDY), 16'h1);
        chk("b2b_di", 16'(DI), 16'h003C);
        tick(2'b01, 8'h00, 1'b0, 1'b0, 8'h00);
        chk("b2b_rdy_ahi", 16'(RDY), 16'h0);
        tick(2'b10, 8'h00, 1'b1, 1'b0, 8'h00);
        chk("b2b_rdy_wd", 16'(RDY), 16'h0);
        tick(2'b11, 8'hC3, 1'b0, 1'b0, 8'h00);
        chk("b2b_wr_req", 16'(mem_req), 16'h1);
        chk("b2b_wr_addr", mem_addr, 16'h0000);
        chk("b2b_wr_we", 16'(mem_we), 16'h1);
        chk("b2b_wr_wdata", 16'(mem_wdata), 16'h00C3);
        tick(2'b00, 8'h00, 1'b0, 1'b1, 8'h99);
        chk("b2b_rdy_done2", 16'(RDY), 16'h1);
        chk("b2b_di_keep", 16'(DI), 16'h003C);
        chk("b2b_err", 16'(err_cnt), 16'h0);
        tick(2'b00, 8'h00, 1'b0, 1'b0, 8'h00);

        // Protocol errors: restart in ADDR_HI, then errors in IDLE until saturation
        tick(2'b01, 8'h10, 1'b0, 1'b0, 8'h00);
        tick(2'b01, 8'h20, 1'b0, 1'b0, 8'h00);
        chk("pe_err1", 16'(err_cnt), 16'h1);
        chk("pe_rdy", 16'(RDY), 16'h0);
        tick(2'b10, 8'h30, 1'b0, 1'b0, 8'h00);
        chk("pe_addr", mem_addr, 16'h3020);
        chk("pe_req", 16'(mem_req), 16'h1);
        tick(2'b00, 8'h00, 1'b0, 1'b1, 8'h11);
        chk("pe_di", 16'(DI), 16'h0011);
        tick(2'b00, 8'h00, 1'b0, 1'b0, 8'h00);
        tick(2'b11, 8'h00, 1'b0, 1'b0, 8'h00);
        chk("pe_err2", 16'(err_cnt), 16'h2);
        chk("pe_rdy_idle", 16'(RDY), 16'h1);
        tick(2'b10, 8'h00, 1'b0, 1'b0, 8'h00);
        chk("pe_err3", 16'(err_cnt), 16'h3);
        tick(2'b11, 8'h00, 1'b0, 1'b0, 8'h00);
        chk("pe_sat4", 16'(err_cnt), 16'h3);
        tick(2'b10, 8'h00, 1'b0, 1'b0, 8'h00);
        chk("pe_sat5", 16'(err_cnt), 16'h3);
        tick(2'b00, 8'h00, 1'b0, 1'b0, 8'h00);

        // Timeout: read ABCD with no ack for four ACCESS cycles
        tick(2'b01, 8'hCD, 1'b0, 1'b0, 8'h00);
        tick(2'b10, 8'hAB, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 3; i++) begin
            chk("to_req_hold", 16'(mem_req), 16'h1);
            chk("to_flag_low", 16'(timeout), 16'h0);
            tick(2'b00, 8'h00, 1'b0, 1'b0, 8'h00);
        end
        chk("to_req_last", 16'(mem_req), 16'h1);
        tick(2'b00, 8'h00, 1'b0, 1'b0, 8'h00);
        chk("to_req_done", 16'(mem_req), 16'h0);
        chk("to_di", 16'(DI), 16'h00FF);
        chk("to_flag", 16'(timeout), 16'h1);
        chk("to_rdy", 16'(RDY), 16'h1);
        tick(2'b00, 8'h00, 1'b0, 1'b1, 8'h55);
        chk("to_late_di", 16'(DI), 16'h00FF);
        chk("to_late_req", 16'(mem_req), 16'h0);
        chk("to_sticky", 16'(timeout), 16'h1);
        chk("to_late_rdy", 16'(RDY), 16'h1);

        // Reset while in WDATA
        tick(2'b01, 8'h44, 1'b0, 1'b0, 8'h00);
        tick(2'b10, 8'h55, 1'b1, 1'b0, 8'h00);
        chk("rwd_rdy_pre", 16'(RDY), 16'h0);
        reset = 1'b1;
        tick(2'b00, 8'h00, 1'b0, 1'b0, 8'h00);
        reset = 1'b0;
        chk_reset_outputs("rwd");

        // Reset while in ACCESS with a coincident ack
        tick(2'b01, 8'h66, 1'b0, 1'b0, 8'h00);
        tick(2'b10, 8'h77, 1'b0, 1'b0, 8'h00);
        chk("racc_req_pre", 16'(mem_req), 16'h1);
        chk("racc_addr_pre", mem_addr, 16'h7766);
        reset = 1'b1;
        tick(2'b00, 8'h00, 1'b0, 1'b1, 8'h99);
        reset = 1'b0;
        chk_reset_outputs("racc");
        tick(2'b00, 8'h00, 1'b0, 1'b0, 8'h00);
        chk("racc_req_after", 16'(mem_req), 16'h0);
        chk("racc_rdy_after", 16'(RDY), 16'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/deserializer.md
# deserializer

Board/memory-side receiver for the CPU's byte-serial bus. It reassembles each CPU bus cycle from the 8-bit `DO` pad stream and its `lh` tag. A cycle arrives as an address low byte, then an address high byte, then a data byte for writes only. The block issues one request/acknowledge memory access per cycle and returns read data on `DI`. It holds `RDY` low to pause the CPU core until the access completes.

## Interface
- `TIMEOUT_CYCLES`, default 255: max cycles waiting for `mem_ack` before abort; 0 disables the timeout.
- `ERR_W`, default 8: width of the saturating protocol-error counter.

- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `DO` in 8: serial byte from the CPU pads.
- `lh` in 2: tag for `DO`. 00 = idle, 01 = address low byte, 10 = address high byte, 11 = write data.
- `WE` in 1: CPU write enable, sampled together with the `lh`=10 byte.
- `DI` out 8: read data returned to the CPU.
- `RDY` out 1: 1 = CPU may advance; 0 = pause.
- `mem_req` out 1: memory access request, level.
- `mem_we` out 1: 1 = write access.
- `mem_addr` out 16: access address.
- `mem_wdata` out 8: write data.
- `mem_ack` in 1: memory completion, one-cycle pulse.
- `mem_rdata` in 8: read data, valid when `mem_ack`=1.
- `timeout` out 1: sticky; set when an access aborted by timeout.
- `err_cnt` out ERR_W: saturating count of protocol errors.

## Operation
- State machine: IDLE, ADDR_HI, WDATA, ACCESS, DONE.
- IDLE:
  - `lh`=01 → latch `DO` into addr[7:0], go to ADDR_HI.
  - `lh`=10 or 11 → protocol error, stay in IDLE.
  - `lh`=00 → stay in IDLE.
- ADDR_HI:
  - `lh`=10 → latch `DO` into addr[15:8] and `WE` into we_r. Go to WDATA if `WE`=1, else to ACCESS.
  - `lh`=01 → protocol error; relatch addr[7:0] and stay in ADDR_HI (restart).
  - `lh`=11 → protocol error, go to IDLE.
  - `lh`=00 → wait in ADDR_HI.
- WDATA:
  - `lh`=11 → latch `DO` into wdata, go to ACCESS.
  - `lh`=01 → protocol error, restart as in ADDR_HI.
  - `lh`=10 → protocol error, go to IDLE.
  - `lh`=00 → wait in WDATA.
- ACCESS:
  - `mem_req`=1; `mem_addr`, `mem_we`, `mem_wdata` driven from latches and held stable.
  - On `mem_ack`: for a read, `DI` ← `mem_rdata`; go to DONE.
  - Any nonzero `lh` here is a protocol error and is otherwise ignored.
  - When the wait counter reaches TIMEOUT_CYCLES (nonzero) without `mem_ack`: `DI` ← 8'hFF for a read, set `timeout`, go to DONE.
- DONE: one cycle, then IDLE. `lh`=01 in DONE is accepted exactly as in IDLE (back-to-back cycles).
- `RDY` = 1 in IDLE and DONE; 0 in ADDR_HI, WDATA, ACCESS.
- `DI` holds its last value until the next read completes; writes do not change `DI`.
- `err_cnt` increments by 1 per error cycle and saturates at all-ones.
- `timeout` is cleared only by `reset`.

## Timing
- Reset values:
  - State IDLE.
  - `DI`=8'h00, `RDY`=1, `mem_req`=0, `mem_we`=0.
  - `mem_addr`=16'h0000, `mem_wdata`=8'h00.
  - `timeout`=0, `err_cnt`=0, wait counter 0.
- `reset` asserted in any state returns to IDLE on that edge; `mem_req` drops the following cycle. A `mem_ack` arriving that edge is discarded.
- `mem_req`, `mem_addr`, `mem_we`, `mem_wdata`, `RDY` are decoded from registered state, with no combinational path from inputs.
- `mem_ack` is accepted in the first ACCESS cycle (zero wait).
- Read, zero wait: `lh`=01 at edge n, `lh`=10 at n+1, ACCESS during n+2 with ack at n+2, DONE at n+3, `DI` valid from n+3.
- Write adds one cycle for the `lh`=11 byte.
- `mem_req` stays high until the edge sampling `mem_ack`; it is 0 in DONE.
- Timeout abort happens after exactly TIMEOUT_CYCLES ACCESS cycles without ack; the wait counter clears on entering ACCESS.
- A `mem_ack` outside ACCESS is ignored.

## Test plan
- Read: `lh`/`DO` = 01/34, 10/12, `WE`=0; `mem_ack` same cycle with `mem_rdata`=A5 → `mem_addr`=1234, `mem_we`=0, one `mem_req` cycle, `DI`=A5, `RDY` low exactly 2 cycles.
- Write with 3 wait cycles: 01/00, 10/02, `WE`=1, then 11/5A → `mem_we`=1, `mem_addr`=0200, `mem_wdata`=5A held 4 cycles, `DI` unchanged.
- Back-to-back: a read to FFFF, with `lh`=01 presented during DONE, then a write to 0000 → both accesses issued, no error, `RDY` high only in DONE.
- Protocol errors: 01/10, 01/20, 10/30, `WE`=0 → `mem_addr`=3020, `err_cnt`=1; `lh`=11 in IDLE → `err_cnt`=2; with `ERR_W`=2, five errors → `err_cnt` saturates at 3.
- Timeout: `TIMEOUT_CYCLES`=4, read with no ack → `mem_req` high 4 cycles, `DI`=FF, `timeout`=1, return to IDLE; a late `mem_ack` is ignored.
- Reset mid-operation: assert `reset` in WDATA and again in ACCESS → next cycle all outputs at reset values, `RDY`=1, no `mem_req`.
